flash_read_responder: RTL and testbench
=======================================

# flash_read_responder

Avalon-MM read-only slave that answers the flash controller's read handshake (read/waitrequest/readdatavalid) on behalf of a synchronous sample memory. It inserts a programmable number of wait states before accepting each command and returns data a fixed number of cycles after acceptance. It supports several reads in flight. It serves as the bus-side model and bridge for audio sample storage, and as the stimulus partner for the flash read master.

## Interface
- ADDR_W, 23, word address width
- DATA_W, 32, read data width
- WAIT_STATES, 2, cycles `avs_waitrequest` stays high before a grant (0 allowed)
- READ_LATENCY, 3, edges from accept to `avs_readdatavalid` (minimum 2)
- MAX_PENDING, 4, maximum accepted reads not yet returned (1..15)

- clk  in  1  clock, rising edge
- reset_all  in  1  reset; asynchronous, active-high
- avs_read  in  1  read request from the master
- avs_address  in  ADDR_W  read word address
- avs_waitrequest  out  1  high means the command is not accepted this cycle
- avs_readdata  out  DATA_W  returned data
- avs_readdatavalid  out  1  single-cycle strobe qualifying `avs_readdata`
- mem_rd  out  1  memory read enable
- mem_addr  out  ADDR_W  memory address
- mem_rdata  in  DATA_W  memory data, valid one edge after `mem_rd`
- busy  out  1  high if the FSM is not in IDLE or pending count is non-zero

## Operation
- FSM states:
  - IDLE: `avs_waitrequest`=1.
    - On `avs_read`=1 and pending<MAX_PENDING: go to GRANT if WAIT_STATES=0, otherwise go to STALL with cnt=WAIT_STATES-1.
  - STALL: `avs_waitrequest`=1.
    - If cnt=0, go to GRANT; otherwise decrement cnt.
    - If `avs_read` drops, go to IDLE (no accept).
  - GRANT: `avs_waitrequest`=0 (registered, no combinational path from `avs_read`).
    - If `avs_read`=1 at the edge, the read is accepted: `mem_rd`=1 and `mem_addr`=`avs_address` during this cycle, and pending increments.
    - Always return to IDLE. Back-to-back accepts are therefore at least 2 edges apart when WAIT_STATES=0.
- Delay line: `mem_rdata` and a valid bit are captured at accept edge A+1. They then pass through READ_LATENCY-1 register stages in total.
- Responses are returned strictly in order, exactly one `avs_readdatavalid` per accepted read.
- Pending counter: increments on accept and decrements on `avs_readdatavalid`. If both happen on the same edge, the value is unchanged.
- Full condition (pending=MAX_PENDING): the FSM stays in IDLE with waitrequest high. It leaves IDLE on the edge after pending drops.
- `avs_readdata` holds its last value when not valid.
- `mem_addr` outputs `avs_address` combinationally only in GRANT; otherwise it is 0.

## Timing
- Let E be the first edge at which IDLE samples `avs_read`=1 with room available. The accept edge is A = E + WAIT_STATES + 1.
- `avs_readdatavalid` is high in the cycle ending at edge A+READ_LATENCY, for one cycle only.
- Reset values:
  - `avs_waitrequest`=1
  - `avs_readdatavalid`=0
  - `avs_readdata`=0
  - `mem_rd`=0
  - `mem_addr`=0
  - `busy`=0
  - state=IDLE, pending=0, delay line cleared
- Reset mid-operation clears everything immediately. In-flight responses are discarded and never returned.
- `avs_read` deasserted in GRANT: no accept, no `mem_rd`, pending unchanged.
- Address changes during STALL are legal; the address sampled at the accept edge is used.

## Structure
- Shared package (`flash_if_pkg`):
  - state enum {IDLE, STALL, GRANT}
  - default ADDR_W/DATA_W constants
  - the function computing the pending-counter width from MAX_PENDING
- Sub-module `resp_delay_line`: parameterised DATA_W and depth. It is a valid+data shift register with async reset, instanced once with depth READ_LATENCY-1.
- Top level holds the FSM, wait counter and pending counter.

## Test plan
- WAIT_STATES=2, READ_LATENCY=3, single read of 0x000010 with `avs_read` first seen at edge 0:
  - waitrequest low only in the cycle ending at edge 3
  - `mem_rd` high at edge 3 with `mem_addr`=0x10
  - `avs_readdatavalid` high only at edge 6, `avs_readdata`=mem[0x10]
- WAIT_STATES=0, READ_LATENCY=2, `avs_read` held continuously with addresses 0,1,2,3:
  - accepts at edges 1,3,5,7
  - valids at 3,5,7,9 with data in order
  - pending never exceeds 2
- MAX_PENDING=1, READ_LATENCY=6, two reads:
  - second read not granted until the first read's valid edge
  - waitrequest stays high throughout that window
- `avs_read` dropped while in STALL, then re-asserted:
  - no `mem_rd`, no valid for the dropped request
  - the new request is accepted WAIT_STATES+1 edges after re-sample
- `reset_all` pulsed one edge before an expected valid:
  - no `avs_readdatavalid` appears
  - all outputs return to reset values
  - `busy`=0
- Simultaneous accept and return:
  - pending count is unchanged across that edge
  - `busy` remains 1

Source files
------------

// File: rtl/flash_if_pkg.sv
// Shared types and sizing helpers for the flash read responder.
package flash_if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        GRANT = 2'd2
    } fsm_state_t;

    localparam int ADDR_W_DEF = 23;
    localparam int DATA_W_DEF = 32;

    // Bits needed to hold any value 0..max_val (never less than 1).
    function automatic int pend_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

endpackage

// File: rtl/resp_delay_line.sv
// Valid+data shift register carrying read responses toward the bus.
// A stage only loads data when a valid word arrives, so the last stage
// keeps presenting the most recently returned word between strobes.
module resp_delay_line #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_all,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]             vld_pipe;
    logic [DEPTH-1:0][DATA_W-1:0] dat_pipe;

    // Shift valid every edge; advance data only alongside a valid bit.
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            if (in_valid) dat_pipe[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign out_valid = vld_pipe[DEPTH-1];
    assign out_data  = dat_pipe[DEPTH-1];

endmodule

// File: rtl/flash_read_responder.sv
// Avalon-MM read-only slave in front of a synchronous sample memory.
// Inserts WAIT_STATES stall cycles before each grant, returns data
// READ_LATENCY edges after accept, and allows up to MAX_PENDING reads
// in flight with strictly in-order responses.
module flash_read_responder
    import flash_if_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int WAIT_STATES  = 2,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 4
) (
    input  logic              clk,
    input  logic              reset_all,
    input  logic              avs_read,
    input  logic [ADDR_W-1:0] avs_address,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int PEND_W = pend_width(MAX_PENDING);
    localparam int CNT_W  = pend_width(WAIT_STATES);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    fsm_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [PEND_W-1:0] pending;
    logic              accept;
    logic              acc_d;
    logic              room;

    assign room = (pending < PEND_MAX);

    // State and wait-state counter registers.
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and bus outputs; waitrequest depends on state only so the
    // master never sees a combinational path from its own read strobe.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        avs_waitrequest = 1'b1;
        mem_rd          = 1'b0;
        mem_addr        = '0;
        accept          = 1'b0;
        case (state)
            IDLE: begin
                if (avs_read && room) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = GRANT;
                    end else begin
                        state_nxt = STALL;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            STALL: begin
                if (!avs_read)         state_nxt = IDLE;
                else if (cnt == '0)    state_nxt = GRANT;
                else                   cnt_nxt   = cnt - CNT_W'(1);
            end
            GRANT: begin
                avs_waitrequest = 1'b0;
                mem_addr        = avs_address;
                if (avs_read) begin
                    accept = 1'b1;
                    mem_rd = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outstanding-read count; accept and return on one edge cancel out.
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            pending <= '0;
        end else begin
            case ({accept, avs_readdatavalid})
                2'b10:   pending <= pending + PEND_W'(1);
                2'b01:   pending <= pending - PEND_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    // Memory answers one edge after mem_rd; this marks that edge's data valid.
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) acc_d <= 1'b0;
        else           acc_d <= accept;
    end

    resp_delay_line #(
        .DATA_W (DATA_W),
        .DEPTH  (READ_LATENCY - 1)
    ) u_dly (
        .clk       (clk),
        .reset_all (reset_all),
        .in_valid  (acc_d),
        .in_data   (mem_rdata),
        .out_valid (avs_readdatavalid),
        .out_data  (avs_readdata)
    );

    assign busy = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_flash_read_responder.sv
// Bench for flash_read_responder: three differently parameterised
// instances driven side by side, each checked every cycle against a
// timeline model (grant edge, queue of due edges and data).
module tb_flash_read_responder;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic reset_all;
    always #5 clk = ~clk;

    logic          rd    [NI];
    logic [AW-1:0] addr  [NI];
    logic          wr    [NI];
    logic [DW-1:0] rdata [NI];
    logic          rvld  [NI];
    logic          mrd   [NI];
    logic [AW-1:0] maddr [NI];
    logic [DW-1:0] mdata [NI];
    logic          busy  [NI];

    flash_read_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(2), .READ_LATENCY(3), .MAX_PENDING(4)) dut0 (
        .clk(clk), .reset_all(reset_all), .avs_read(rd[0]), .avs_address(addr[0]),
        .avs_waitrequest(wr[0]), .avs_readdata(rdata[0]), .avs_readdatavalid(rvld[0]),
        .mem_rd(mrd[0]), .mem_addr(maddr[0]), .mem_rdata(mdata[0]), .busy(busy[0]));

    flash_read_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0), .READ_LATENCY(2), .MAX_PENDING(4)) dut1 (
        .clk(clk), .reset_all(reset_all), .avs_read(rd[1]), .avs_address(addr[1]),
        .avs_waitrequest(wr[1]), .avs_readdata(rdata[1]), .avs_readdatavalid(rvld[1]),
        .mem_rd(mrd[1]), .mem_addr(maddr[1]), .mem_rdata(mdata[1]), .busy(busy[1]));

    flash_read_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(1), .READ_LATENCY(6), .MAX_PENDING(1)) dut2 (
        .clk(clk), .reset_all(reset_all), .avs_read(rd[2]), .avs_address(addr[2]),
        .avs_waitrequest(wr[2]), .avs_readdata(rdata[2]), .avs_readdatavalid(rvld[2]),
        .mem_rd(mrd[2]), .mem_addr(maddr[2]), .mem_rdata(mdata[2]), .busy(busy[2]));

    function automatic int ws_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 0 : 1;
    endfunction
    function automatic int rl_of(input int k);
        return (k == 0) ? 3 : (k == 1) ? 2 : 6;
    endfunction
    function automatic int mp_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return ({9'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Sample memory: data one edge after mem_rd, noise otherwise.
    always @(posedge clk)
        for (int k = 0; k < NI; k++)
            mdata[k] <= mrd[k] ? memf(maddr[k]) : DW'($urandom);

    int n_cmp = 0;
    int n_bad = 0;
    int ed    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ed);
        end
    endtask

    // Reference model: edge at which the pending grant lands (-1 none),
    // plus in-order queue of (due edge, data) for accepted reads.
    int            acc_at [NI];
    int            qd     [NI][16];
    logic [DW-1:0] qv     [NI][16];
    int            qn     [NI];
    logic [DW-1:0] last_d [NI];

    logic          d_rst;
    logic          d_rd   [NI];
    logic [AW-1:0] d_addr [NI];
    logic          saw_acc [NI];
    logic          saw_vld [NI];
    logic          saw_wrl [NI];
    logic          saw_busy[NI];

    task automatic model_clear();
        for (int k = 0; k < NI; k++) begin
            acc_at[k] = -1;
            qn[k]     = 0;
            last_d[k] = '0;
        end
    endtask

    // One clock: drive at negedge, check just after, advance model at posedge.
    task automatic step();
        @(negedge clk);
        reset_all = d_rst;
        for (int k = 0; k < NI; k++) begin
            rd[k]   = d_rd[k];
            addr[k] = d_addr[k];
        end
        #1;
        if (d_rst) model_clear();
        for (int k = 0; k < NI; k++) begin
            logic g, v;
            g = (acc_at[k] == ed);
            v = (qn[k] > 0) && (qd[k][0] == ed);
            check($sformatf("wr%0d", k),    wr[k],    !g);
            check($sformatf("mrd%0d", k),   mrd[k],   g && d_rd[k]);
            check($sformatf("maddr%0d", k), maddr[k], g ? d_addr[k] : '0);
            check($sformatf("vld%0d", k),   rvld[k],  v);
            check($sformatf("rdat%0d", k),  rdata[k], v ? qv[k][0] : last_d[k]);
            check($sformatf("busy%0d", k),  busy[k],  (acc_at[k] != -1) || (qn[k] > 0));
            saw_acc[k]  = rd[k] && !wr[k];
            saw_vld[k]  = rvld[k];
            saw_wrl[k]  = !wr[k];
            saw_busy[k] = busy[k];
        end
        @(posedge clk);
        if (!d_rst) begin
            for (int k = 0; k < NI; k++) begin
                int pend;
                pend = qn[k];
                if (acc_at[k] == ed) begin
                    if (d_rd[k]) begin
                        qd[k][qn[k]] = ed + rl_of(k);
                        qv[k][qn[k]] = memf(d_addr[k]);
                        qn[k]++;
                    end
                    acc_at[k] = -1;
                end else if (acc_at[k] > ed) begin
                    if (!d_rd[k]) acc_at[k] = -1;
                end else if (d_rd[k] && pend < mp_of(k)) begin
                    acc_at[k] = ed + ws_of(k) + 1;
                end
                if (qn[k] > 0 && qd[k][0] == ed) begin
                    last_d[k] = qv[k][0];
                    for (int j = 1; j < qn[k]; j++) begin
                        qd[k][j-1] = qd[k][j];
                        qv[k][j-1] = qv[k][j];
                    end
                    qn[k]--;
                end
            end
        end
        ed++;
    endtask

    task automatic idle_all();
        for (int k = 0; k < NI; k++) begin
            d_rd[k]   = 1'b0;
            d_addr[k] = '0;
        end
    endtask

    initial begin
        logic [AW-1:0] lst [NI][4];
        int nl [NI];
        int idx[NI];
        int acc_e[NI][4];
        int na [NI];
        int vld_e[NI][4];
        int nv [NI];
        int wrl[NI];
        int s;
        logic done;
        int nvr;

        reset_all = 1'b1;
        d_rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            rd[k] = 1'b0;
            addr[k] = '0;
        end
        idle_all();
        model_clear();
        repeat (3) step();
        #2;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_wr%0d", k),    wr[k],    1'b1);
            check($sformatf("rst_vld%0d", k),   rvld[k],  1'b0);
            check($sformatf("rst_rdat%0d", k),  rdata[k], '0);
            check($sformatf("rst_mrd%0d", k),   mrd[k],   1'b0);
            check($sformatf("rst_maddr%0d", k), maddr[k], '0);
            check($sformatf("rst_busy%0d", k),  busy[k],  1'b0);
        end
        d_rst = 1'b0;
        repeat (2) step();

        // Directed: single read, back-to-back stream, full-blocked second read.
        lst[0][0] = 23'h10;
        for (int i = 0; i < 4; i++) lst[1][i] = AW'(i);
        lst[2][0] = 23'h20;
        lst[2][1] = 23'h21;
        nl[0] = 1; nl[1] = 4; nl[2] = 2;
        for (int k = 0; k < NI; k++) begin
            idx[k] = 0; na[k] = 0; nv[k] = 0; wrl[k] = 0;
        end
        s = ed;
        repeat (25) begin
            for (int k = 0; k < NI; k++) begin
                d_rd[k]   = (idx[k] < nl[k]);
                d_addr[k] = (idx[k] < nl[k]) ? lst[k][idx[k]] : '0;
            end
            step();
            for (int k = 0; k < NI; k++) begin
                if (saw_acc[k]) begin
                    if (na[k] < 4) acc_e[k][na[k]] = ed - 1 - s;
                    na[k]++;
                    idx[k]++;
                end
                if (saw_vld[k]) begin
                    if (nv[k] < 4) vld_e[k][nv[k]] = ed - 1 - s;
                    nv[k]++;
                end
                if (saw_wrl[k]) wrl[k]++;
            end
        end
        check("d0_nacc", na[0], 1);
        check("d0_acc", acc_e[0][0], 3);
        check("d0_nwrl", wrl[0], 1);
        check("d0_nvld", nv[0], 1);
        check("d0_vld", vld_e[0][0], 6);
        check("d1_nacc", na[1], 4);
        check("d1_nvld", nv[1], 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("d1_acc%0d", i), acc_e[1][i], 1 + 2 * i);
            check($sformatf("d1_vld%0d", i), vld_e[1][i], 3 + 2 * i);
        end
        check("d2_nacc", na[2], 2);
        check("d2_nvld", nv[2], 2);
        check("d2_acc0", acc_e[2][0], 2);
        check("d2_vld0", vld_e[2][0], 8);
        check("d2_acc1", acc_e[2][1], 11);
        check("d2_vld1", vld_e[2][1], 17);
        check("d2_nwrl", wrl[2], 2);

        // Directed: read dropped in STALL, re-asserted three edges later.
        idle_all();
        na[0] = 0; nv[0] = 0;
        done = 1'b0;
        s = ed;
        for (int i = 0; i < 14; i++) begin
            d_rd[0]   = (i == 0) || (i >= 3 && !done);
            d_addr[0] = (i == 0) ? 23'h55 : 23'h66;
            step();
            if (saw_acc[0]) begin
                acc_e[0][0] = ed - 1 - s;
                na[0]++;
                done = 1'b1;
            end
            if (saw_vld[0]) begin
                vld_e[0][0] = ed - 1 - s;
                nv[0]++;
            end
        end
        check("drop_nacc", na[0], 1);
        check("drop_acc", acc_e[0][0], 6);
        check("drop_nvld", nv[0], 1);
        check("drop_vld", vld_e[0][0], 9);

        // Random traffic with occasional reset pulses.
        repeat (1500) begin
            d_rst = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < NI; k++) begin
                d_rd[k]   = ($urandom_range(0, 3) != 0);
                d_addr[k] = AW'($urandom);
            end
            step();
        end
        d_rst = 1'b0;
        idle_all();
        repeat (20) step();

        // Reset one edge before an expected valid: the response is lost.
        done = 1'b0;
        nvr = 0;
        for (int i = 0; i < 16; i++) begin
            d_rst     = (i == 5);
            d_rd[0]   = (i < 5) && !done;
            d_addr[0] = 23'h5;
            step();
            if (saw_acc[0]) done = 1'b1;
            if (i >= 5 && saw_vld[0]) nvr++;
        end
        check("rstv_acc", done, 1'b1);
        check("rstv_nvld", nvr, 0);
        check("rstv_busy", saw_busy[0], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
